// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetch_state_t : sequencer states (START, FETCH, DELIVER)
//   DEF_ADDR_W    : default PC / instruction-address width
//   DEF_DATA_W    : default instruction width
//   DEF_RESET_PC  : default PC loaded on reset
//   NOP           : MIPS32 NOP encoding
package fetch_pkg;

    typedef enum logic [1:0] {
        START,
        FETCH,
        DELIVER
    } fetch_state_t;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues word-addressed fetches over a req/ack
// instruction-memory handshake and hands one instruction at a time to decode.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   redirect_valid  : branch/jump redirect pulse from execute
//   redirect_pc     : redirect target
//   stall           : decode cannot accept the presented instruction
//   imem_req/addr   : fetch request and address (stable until ack)
//   imem_ack/rdata  : fetch completion and instruction word
//   instr_valid     : instr / instr_pc presented to decode
//   instr, instr_pc : delivered instruction and its address
//   pc              : address of the next fetch
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state_q, state_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] pending_q, pending_d;

    logic              imem_req_d;
    logic [ADDR_W-1:0] imem_addr_d;
    logic              instr_valid_d;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] instr_pc_d;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        state_d       = state_q;
        squash_d      = squash_q;
        pending_d     = pending_q;
        imem_req_d    = imem_req;
        imem_addr_d   = imem_addr;
        instr_valid_d = instr_valid;
        instr_d       = instr;
        instr_pc_d    = instr_pc;
        pc_d          = pc;

        unique case (state_q)
            START: begin
                // Nothing is in flight yet, so a redirect here is taken directly.
                if (redirect_valid) begin
                    pending_d = redirect_pc;
                    pc_d      = redirect_pc;
                end
                imem_req_d  = 1'b1;
                imem_addr_d = pc_d;
                state_d     = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (squash_q || redirect_valid) begin
                        // Returned word belongs to the wrong path: drop it and refetch.
                        pc_d        = redirect_valid ? redirect_pc : pending_q;
                        imem_addr_d = pc_d;
                        squash_d    = 1'b0;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc;
                        pc_d          = pc + ADDR_W'(1);
                        instr_valid_d = 1'b1;
                        imem_req_d    = 1'b0;
                        state_d       = DELIVER;
                    end
                end else if (redirect_valid) begin
                    // Request cannot be cancelled; remember the newest target.
                    squash_d  = 1'b1;
                    pending_d = redirect_pc;
                end
            end
            DELIVER: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_pc;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = redirect_pc;
                    state_d       = FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = pc;
                    state_d       = FETCH;
                end
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= START;
            squash_q    <= 1'b0;
            pending_q   <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            pc          <= RESET_PC;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            pending_q   <= pending_d;
            imem_req    <= imem_req_d;
            imem_addr   <= imem_addr_d;
            instr_valid <= instr_valid_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            pc          <= pc_d;
        end
    end

    // Delivery and fetching never overlap.
    valid_excludes_req: assert property (@(posedge clk) disable iff (reset)
        instr_valid |-> !imem_req);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the fetch rules.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    // Reference model: a request is either outstanding, an instruction is held, or the
    // sequencer is booting. Redirects seen during a request queue up; the newest wins.
    bit          m_boot;
    bit          m_req;
    bit          m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] redir_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_boot  = 1'b1;
            m_req   = 1'b0;
            m_valid = 1'b0;
            m_addr  = 32'h0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_ipc   = 32'h0;
            redir_q.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (redirect_valid) m_pc = redirect_pc;
            m_req  = 1'b1;
            m_addr = m_pc;
        end else if (m_req) begin
            if (redirect_valid) redir_q.push_back(redirect_pc);
            if (imem_ack) begin
                if (redir_q.size() != 0) begin
                    m_pc   = redir_q[$];
                    m_addr = m_pc;
                    redir_q.delete();
                end else begin
                    m_instr = imem_rdata;
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 32'd1;
                    m_valid = 1'b1;
                    m_req   = 1'b0;
                end
            end
        end else if (m_valid) begin
            if (redirect_valid) m_pc = redirect_pc;
            if (redirect_valid || !stall) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_pc;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: present memory data, advance model at the edge, compare #1 later,
    // then return at the falling edge with single-cycle pulses cleared.
    task automatic cycle();
        imem_rdata = mem_word(m_addr);
        @(posedge clk);
        model_step();
        #1;
        check("imem_req", {31'h0, imem_req}, {31'h0, m_req});
        check("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
        check("imem_addr", imem_addr, m_addr);
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        @(negedge clk);
        redirect_valid = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic run_until_valid(input int budget);
        int n = 0;
        imem_ack = 1'b1;
        stall    = 1'b0;
        while (!m_valid && n < budget) begin
            cycle();
            n++;
        end
        if (!m_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid: no delivery within %0d cycles", budget);
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_ack       = 1'b1;   // ack during reset must be ignored
        imem_rdata     = NOP;
        m_addr         = 32'h0;
        @(negedge clk);

        // Reset with a stray ack, then straight-line fetch with immediate acks.
        reset = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) cycle();

        // Stall hold for three cycles on a delivered instruction.
        run_until_valid(10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        stall = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // In-flight squash: fetch at 5, two redirects while ack is withheld.
        run_until_valid(10);
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h5;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cycle();
        imem_ack = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) cycle();

        // Redirect beats stall during delivery.
        run_until_valid(10);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        stall = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // PC wrap at the top of the address space.
        run_until_valid(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        cycle();
        for (int i = 0; i < 6; i++) cycle();

        // Redirect and ack in the same cycle while fetching.
        run_until_valid(10);
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234;
        cycle();
        for (int i = 0; i < 3; i++) cycle();

        // Reset mid-fetch with squash pending and an ack in the reset cycle.
        run_until_valid(10);
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h150;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        imem_ack = 1'b1;
        reset    = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) cycle();

        // Redirect arriving in the boot cycle after reset.
        reset = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        cycle();
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ?
                             32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : 32'($urandom);
            stall          = ($urandom_range(0, 2) == 0);
            imem_ack       = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
